// File: rtl/result_reader.sv
// Drains a path result (length word + node IDs) from the core's output memory
// as a valid/ready beat stream. Define RESULT_READER_HDR_EN to emit the length word as a header beat.
module result_reader #(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              finish,
  input  logic              n_exist,
  input  logic [DATA_W-1:0] final_output,
  output logic [ADDR_W-1:0] output_address,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              done,
  output logic [ADDR_W-1:0] beat_count
);

  typedef enum logic [1:0] {
    IDLE,
    LEN,
    STREAM,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic              finish_q;
  logic              arm_q, arm_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] rem_q, rem_d;
  logic [ADDR_W-1:0] beat_q, beat_d;
  logic [ADDR_W-1:0] len_clamped;
  logic              start;
  logic              transfer;

  // A finish level still high when reset releases must fall before it can start a drain.
  assign start    = finish & ~finish_q & arm_q;
  assign transfer = valid_q & out_ready;

  always_comb begin
    len_clamped = final_output[ADDR_W-1:0];
    if ((final_output >> ADDR_W) != '0) len_clamped = '1;
  end

  always_comb begin
    state_d = state_q;
    arm_d   = arm_q | ~finish;
    addr_d  = addr_q;
    data_d  = data_q;
    valid_d = valid_q;
    rem_d   = rem_q;
    beat_d  = beat_q;
    unique case (state_q)
      IDLE: begin
        addr_d  = '0;
        valid_d = 1'b0;
        if (start) begin
          beat_d = '0;
          if (n_exist) begin
            state_d = STREAM;
            data_d  = '1;
            valid_d = 1'b1;
            rem_d   = '0;
          end else begin
            state_d = LEN;
          end
        end
      end
      LEN: begin
        rem_d   = len_clamped;
        addr_d  = ADDR_W'(1);
        state_d = STREAM;
`ifdef RESULT_READER_HDR_EN
        data_d  = final_output;
        valid_d = 1'b1;
`endif
      end
      STREAM: begin
        if (transfer) beat_d = beat_q + ADDR_W'(1);
        if (!valid_q || transfer) begin
          if (rem_q != '0) begin
            data_d  = final_output;
            valid_d = 1'b1;
            rem_d   = rem_q - ADDR_W'(1);
            // Saturate so a clamped length never wraps the read address.
            addr_d  = (addr_q == '1) ? addr_q : addr_q + ADDR_W'(1);
          end else begin
            valid_d = 1'b0;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        valid_d = 1'b0;
        if (!finish) begin
          state_d = IDLE;
          addr_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      finish_q <= 1'b0;
      arm_q    <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      rem_q    <= '0;
      beat_q   <= '0;
    end else begin
      state_q  <= state_d;
      finish_q <= finish;
      arm_q    <= arm_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      rem_q    <= rem_d;
      beat_q   <= beat_d;
    end
  end

  assign output_address = addr_q;
  assign out_data       = data_q;
  assign out_valid      = valid_q;
  assign out_last       = valid_q & (rem_q == '0) & (state_q == STREAM);
  assign done           = (state_q == DONE);
  assign beat_count     = beat_q;

endmodule

// File: tb/tb_result_reader.sv
// Bench for result_reader: table of drain scenarios checked against a queue model of the memory path.
module tb_result_reader;
  localparam int AW = 14;
  localparam int DW = 16;

  logic          clock = 1'b0;
  logic          reset;
  logic          finish;
  logic          n_exist;
  logic [DW-1:0] final_output;
  logic [AW-1:0] output_address;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          done;
  logic [AW-1:0] beat_count;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  int unsigned   n_total = 0;
  int unsigned   n_pass  = 0;
  bit            hdr;

  always #5 clock = ~clock;
  assign final_output = mem[output_address];

  result_reader #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clock          (clock),
    .reset          (reset),
    .finish         (finish),
    .n_exist        (n_exist),
    .final_output   (final_output),
    .output_address (output_address),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_last       (out_last),
    .done           (done),
    .beat_count     (beat_count)
  );

  typedef struct {
    logic [15:0] word0;
    bit          nex;
    int          mode;      // 0: ready=1, 1: toggle, 2: random
    bit          drop;      // drop finish after first beat
    int          exp_beats; // node beats without header
    int          exp_addr;  // output_address while done
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  task automatic zero_outputs(input string tag);
    chk({tag, "_addr"},  32'(output_address), 0);
    chk({tag, "_data"},  32'(out_data), 0);
    chk({tag, "_valid"}, 32'(out_valid), 0);
    chk({tag, "_last"},  32'(out_last), 0);
    chk({tag, "_done"},  32'(done), 0);
    chk({tag, "_bcnt"},  32'(beat_count), 0);
  endtask

  task automatic run_drain(input vec_t v, input int idx);
    logic [15:0] expq[$];
    int          lc;
    int          beats;
    bit          stall_prev;
    logic [15:0] pd;
    logic [AW-1:0] pa;
    logic        pl;
    int          exp_n;
    for (int k = 0; k < (1 << AW); k++) mem[k] = 16'($urandom);
    mem[0] = v.word0;
    if (idx == 0) begin
      mem[1] = 16'd7; mem[2] = 16'd2; mem[3] = 16'd9;
    end
    lc = 0;
    if (v.nex) expq.push_back(16'hFFFF);
    else begin
      lc = (v.word0[15:14] != 2'b00) ? 16383 : int'(v.word0[13:0]);
      if (hdr) expq.push_back(v.word0);
      for (int k = 1; k <= lc; k++) expq.push_back(mem[k]);
    end
    exp_n = v.exp_beats + ((hdr && !v.nex) ? 1 : 0);
    beats = 0;
    stall_prev = 1'b0;
    pd = '0; pa = '0; pl = 1'b0;
    n_exist = v.nex;
    finish  = 1'b1;
    for (int cyc = 1; cyc <= 40000; cyc++) begin
      @(negedge clock);
      if (stall_prev) begin
        chk("stall_valid", 32'(out_valid), 1);
        chk("stall_data",  32'(out_data), 32'(pd));
        chk("stall_addr",  32'(output_address), 32'(pa));
        chk("stall_last",  32'(out_last), 32'(pl));
      end
      case (v.mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 2 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (v.mode == 0 && !v.nex && lc > 0 && cyc == 3)
        chk("first_node_lat", {15'd0, out_valid, out_data}, {15'd0, 1'b1, mem[1]});
      if (out_valid && out_ready) begin
        if (beats < expq.size()) begin
          chk("beat_data", 32'(out_data), 32'(expq[beats]));
          chk("beat_last", 32'(out_last), 32'(beats == expq.size() - 1));
        end else chk("extra_beat", 32'(out_valid), 0);
        beats++;
      end
      if (v.drop && beats >= 1) finish = 1'b0;
      stall_prev = out_valid && !out_ready;
      pd = out_data; pa = output_address; pl = out_last;
      if (done) break;
    end
    chk("done_reached", 32'(done), 1);
    chk("done_valid",   32'(out_valid), 0);
    chk("beat_total",   32'(beats), 32'(exp_n));
    chk("beat_count",   32'(beat_count), 32'(exp_n) & 32'h3FFF);
    chk("done_addr",    32'(output_address), 32'(v.exp_addr));
    finish = 1'b0;
    repeat (2) @(negedge clock);
    chk("idle_done", 32'(done), 0);
    chk("idle_addr", 32'(output_address), 0);
  endtask

  initial begin
    int got;
`ifdef RESULT_READER_HDR_EN
    hdr = 1'b1;
`else
    hdr = 1'b0;
`endif
    tbl[0] = '{16'd3,     1'b0, 0, 1'b0, 3,     4};
    tbl[1] = '{16'd2,     1'b0, 1, 1'b0, 2,     3};
    tbl[2] = '{16'd5,     1'b1, 0, 1'b0, 1,     0};
    tbl[3] = '{16'd0,     1'b0, 0, 1'b0, 0,     1};
    tbl[4] = '{16'd6,     1'b0, 2, 1'b1, 6,     7};
    tbl[5] = '{16'd1,     1'b0, 1, 1'b0, 1,     2};
    tbl[6] = '{16'hC005,  1'b0, 0, 1'b0, 16383, 16383};

    reset = 1'b0; finish = 1'b0; n_exist = 1'b0; out_ready = 1'b0;
    for (int k = 0; k < (1 << AW); k++) mem[k] = '0;
    #1 zero_outputs("reset");
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    for (int i = 0; i < 7; i++) run_drain(tbl[i], i);

    // Reset in the middle of a stream, finish left high across release
    for (int k = 0; k < (1 << AW); k++) mem[k] = 16'($urandom);
    mem[0] = 16'd5;
    n_exist = 1'b0; out_ready = 1'b1; finish = 1'b1;
    got = 0;
    for (int cyc = 0; cyc < 20 && got == 0; cyc++) begin
      @(negedge clock);
      if (out_valid) got = 1;
    end
    chk("mid_first_beat", 32'(got), 1);
    @(posedge clock);
    #2 reset = 1'b0;
    #1 zero_outputs("async_rst");
    repeat (2) @(negedge clock);
    reset = 1'b1;
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(negedge clock);
      chk("post_rst_valid", 32'(out_valid), 0);
      chk("post_rst_addr",  32'(output_address), 0);
    end
    finish = 1'b0;
    repeat (2) @(negedge clock);
    run_drain(tbl[0], 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/result_reader.md
RESULT_READER -- requirements
Module: result_reader

Interface
REQ-001 Parameter: ADDR_W, default 14, output-memory address width.
REQ-002 Parameter: DATA_W, default 16, output-memory word width.
REQ-003 Port: clock  input  1  single clock; all state on rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-low reset.
REQ-005 Port: finish  input  1  core completion level; rising edge starts a drain.
REQ-006 Port: n_exist  input  1  core flag: no path exists; sampled on the finish rising edge.
REQ-007 Port: final_output  input  DATA_W  output-memory read data; combinational from output_address.
REQ-008 Port: output_address  output  ADDR_W  registered output-memory read address.
REQ-009 Port: out_data  output  DATA_W  result beat.
REQ-010 Port: out_valid  output  1  out_data valid.
REQ-011 Port: out_ready  input  1  sink accepts the beat.
REQ-012 Port: out_last  output  1  current beat is final.
REQ-013 Port: done  output  1  drain complete.
REQ-014 Port: beat_count  output  ADDR_W  accepted beats since the last start.

Function
REQ-015 Memory format: word 0 holds path length L; words 1..L hold path node IDs in order.
REQ-016 States: IDLE, LEN, STREAM, DONE.
REQ-017 Edge detect: finish is registered; start = finish & ~finish_q; start is ignored outside IDLE.
REQ-018 IDLE: output_address=0, out_valid=0, done=0; start with n_exist=0 -> LEN and clear beat_count.
REQ-019 IDLE: start with n_exist=1 -> STREAM with out_data=all-ones, out_valid=1, remaining=0, and beat_count cleared.
REQ-020 LEN (one cycle): remaining = final_output[ADDR_W-1:0], clamped to 2^ADDR_W-1 if any higher bit is set; output_address<=1; next state STREAM.
REQ-021 Transfer occurs on a cycle where out_valid and out_ready are both 1; beat_count increments by 1 per transfer.
REQ-022 STREAM load condition: out_valid=0 or a transfer occurs.
REQ-023 On a load with remaining!=0: out_data<=final_output, out_valid<=1, output_address+=1, remaining-=1.
REQ-024 On a load with remaining==0: out_valid<=0 and next state DONE.
REQ-025 L=0 (without header): no beats; STREAM -> DONE on the next cycle.
REQ-026 Throughput is one beat per cycle while out_ready=1; the first node beat is valid 2 cycles after the start edge.
REQ-027 While out_valid=1 and out_ready=0, out_data, out_last and output_address shall hold stable.
REQ-028 out_last = out_valid & (remaining==0) & (state==STREAM).
REQ-029 DONE: done=1 and out_valid=0; the block returns to IDLE when finish=0.
REQ-030 A finish fall during LEN or STREAM is ignored and the drain completes.
REQ-031 output_address never exceeds 2^ADDR_W-1; there is no wrap.

Reset
REQ-032 reset=0 asynchronously forces IDLE.
REQ-033 Reset clears output_address, out_data, out_valid, out_last, done, beat_count, remaining and finish_q to 0.
REQ-034 Reset mid-stream discards the drain; no beat is emitted until a new start edge after reset release.

Configuration
REQ-035 Macro RESULT_READER_HDR_EN.
REQ-036 Defined: in LEN, out_data<=final_output (the raw length word) and out_valid<=1, so the header is the first beat; node beats follow, and L=0 gives exactly one beat with out_last=1.
REQ-037 Undefined: no header beat; behaviour is as REQ-020..REQ-025.
REQ-038 The n_exist path (REQ-019) emits one all-ones beat regardless of the macro.

Verification
REQ-039 Memory [3,7,2,9], finish rise, out_ready=1, macro undefined -> beats 7,2,9 on consecutive cycles; out_last on the 9 beat; beat_count=3; done=1.
REQ-040 Same memory, macro defined -> beats 3,7,2,9; out_last only on 9; beat_count=4.
REQ-041 n_exist=1 at finish rise -> single beat 16'hFFFF with out_last=1; output_address stays 0; done=1.
REQ-042 L=2, out_ready toggles 0/1 each cycle -> out_data stable while stalled; exactly 2 beats accepted.
REQ-043 Word 0 = 16'hC005 -> remaining clamped to 16383; the stream stops at address 16383 with no address wrap.
REQ-044 reset=0 mid-stream after 1 beat -> all outputs 0 immediately; after release with finish held high, no activity until finish falls and rises again.
